// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read handshake plus the held-instruction
// interface toward decode/branch logic.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                IMemReq;
    logic [PC_WIDTH-1:0] IMemAddr;
    logic                IMemReady;
    logic [31:0]         IMemRdata;
    logic [31:0]         Instruction;
    logic                InstrValid;
    logic                InstrAck;
    logic                PCSrc;
    logic                Jump;
    logic [PC_WIDTH-1:0] PCOut;
    logic [PC_WIDTH-1:0] PCPlus4;

    modport master (
        output IMemReq, IMemAddr, Instruction, InstrValid, PCOut, PCPlus4,
        input  IMemReady, IMemRdata, InstrAck, PCSrc, Jump
    );

    modport slave (
        input  IMemReq, IMemAddr, Instruction, InstrValid, PCOut, PCPlus4,
        output IMemReady, IMemRdata, InstrAck, PCSrc, Jump
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory over a ready handshake and
// presents each word until acknowledged, then steps to sequential/branch/jump target.
//
// state   | meaning
// S_IDLE  | first cycle after reset release, nothing requested
// S_FETCH | read request outstanding at pc, waiting for IMemReady
// S_VALID | instruction held on outputs, waiting for InstrAck
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] branch_off;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] next_pc;

    // The memory address is the PC register itself, so it cannot move mid-request.
    assign bus.IMemAddr = pc;

    always_comb begin
        branch_off  = {{(PC_WIDTH-18){bus.Instruction[15]}}, bus.Instruction[15:0], 2'b00};
        jump_target = {bus.PCPlus4[PC_WIDTH-1:28], bus.Instruction[25:0], 2'b00};
        next_pc     = bus.PCPlus4;
        if (bus.Jump) begin
            next_pc = jump_target;
        end else if (bus.PCSrc) begin
            next_pc = bus.PCPlus4 + branch_off;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            bus.IMemReq     <= 1'b0;
            bus.Instruction <= '0;
            bus.InstrValid  <= 1'b0;
            bus.PCOut       <= RESET_PC;
            bus.PCPlus4     <= RESET_PC + PC_WIDTH'(4);
        end else begin
            case (state)
                S_IDLE: begin
                    state       <= S_FETCH;
                    bus.IMemReq <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.IMemReady) begin
                        state           <= S_VALID;
                        bus.IMemReq     <= 1'b0;
                        bus.Instruction <= bus.IMemRdata;
                        bus.InstrValid  <= 1'b1;
                        bus.PCOut       <= pc;
                        bus.PCPlus4     <= pc + PC_WIDTH'(4);
                    end
                end
                S_VALID: begin
                    if (bus.InstrAck) begin
                        state          <= S_FETCH;
                        pc             <= next_pc;
                        bus.IMemReq    <= 1'b1;
                        bus.InstrValid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    bus.IMemReq <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected fetch addresses are queued
// when an ack is issued and popped when the next memory request appears.
module tb_instruction_fetch_unit;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    instruction_fetch_unit_if #(.PC_WIDTH(32)) bus0 ();
    instruction_fetch_unit_if #(.PC_WIDTH(32)) bus1 ();

    instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut0 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus0)
    );

    instruction_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0400)) dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus0.IMemReady = 1'b0;
        bus0.IMemRdata = '0;
        bus0.InstrAck  = 1'b0;
        bus0.PCSrc     = 1'b0;
        bus0.Jump      = 1'b0;
    endtask

    // Wait for a request, check it against the scoreboard, optionally stall, then respond.
    task automatic fetch(input logic [31:0] word, input int wait_cyc);
        int          n;
        logic [31:0] exp_addr;
        n = 0;
        while (bus0.IMemReq !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("req_seen", {31'b0, bus0.IMemReq}, 32'd1);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("fetch_addr", bus0.IMemAddr, exp_addr);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge Clk);
            check("wait_req", {31'b0, bus0.IMemReq}, 32'd1);
            check("wait_addr", bus0.IMemAddr, exp_addr);
            check("wait_valid", {31'b0, bus0.InstrValid}, 32'd0);
        end
        bus0.IMemReady = 1'b1;
        bus0.IMemRdata = word;
        @(negedge Clk);
        bus0.IMemReady = 1'b0;
        bus0.IMemRdata = '0;
        check("valid", {31'b0, bus0.InstrValid}, 32'd1);
        check("instr", bus0.Instruction, word);
        check("pcout", bus0.PCOut, exp_addr);
        check("pcplus4", bus0.PCPlus4, exp_addr + 32'd4);
        check("req_drop", {31'b0, bus0.IMemReq}, 32'd0);
        cur_pc    = exp_addr;
        cur_instr = word;
    endtask

    // Hold for some cycles (with a stray IMemReady), then ack; exp_next is the plan's target.
    task automatic ack(input logic src, input logic jmp, input int hold, input logic [31:0] exp_next);
        for (int i = 0; i < hold; i++) begin
            bus0.IMemReady = 1'b1;
            bus0.IMemRdata = 32'hDEAD_BEEF;
            @(negedge Clk);
            check("hold_valid", {31'b0, bus0.InstrValid}, 32'd1);
            check("hold_instr", bus0.Instruction, cur_instr);
            check("hold_pcout", bus0.PCOut, cur_pc);
            check("hold_req", {31'b0, bus0.IMemReq}, 32'd0);
        end
        bus0.IMemReady = 1'b0;
        bus0.IMemRdata = '0;
        exp_q.push_back(exp_next);
        bus0.InstrAck = 1'b1;
        bus0.PCSrc    = src;
        bus0.Jump     = jmp;
        @(negedge Clk);
        drive_idle();
        check("ack_valid", {31'b0, bus0.InstrValid}, 32'd0);
        check("ack_req", {31'b0, bus0.IMemReq}, 32'd1);
    endtask

    initial begin
        drive_idle();
        bus1.IMemReady = 1'b0;
        bus1.IMemRdata = '0;
        bus1.InstrAck  = 1'b0;
        bus1.PCSrc     = 1'b0;
        bus1.Jump      = 1'b0;
        cur_pc         = '0;
        cur_instr      = '0;
        Rst            = 1'b1;
        repeat (2) @(negedge Clk);

        check("rst_req", {31'b0, bus0.IMemReq}, 32'd0);
        check("rst_addr", bus0.IMemAddr, 32'h0);
        check("rst_instr", bus0.Instruction, 32'h0);
        check("rst_valid", {31'b0, bus0.InstrValid}, 32'd0);
        check("rst_pcout", bus0.PCOut, 32'h0);
        check("rst_pcplus4", bus0.PCPlus4, 32'h4);
        check("rst1_addr", bus1.IMemAddr, 32'h400);
        check("rst1_pcplus4", bus1.PCPlus4, 32'h404);

        Rst = 1'b0;
        @(negedge Clk);
        check("cyc1_req", {31'b0, bus0.IMemReq}, 32'd1);
        check("cyc1_req_dut1", {31'b0, bus1.IMemReq}, 32'd1);
        check("cyc1_addr_dut1", bus1.IMemAddr, 32'h400);

        exp_q.push_back(32'h0);
        fetch(32'h0022_1820, 0);
        ack(1'b0, 1'b0, 3, 32'h4);
        fetch(32'h012A_4020, 0);
        ack(1'b0, 1'b0, 0, 32'h8);
        fetch(32'h8C08_0000, 0);
        ack(1'b0, 1'b0, 0, 32'hC);
        fetch(32'hAC08_0004, 0);
        ack(1'b0, 1'b0, 0, 32'h10);
        fetch(32'h0800_0002, 0);
        ack(1'b1, 1'b1, 0, 32'h8);
        fetch(32'h1022_0004, 0);
        ack(1'b1, 1'b0, 0, 32'h1C);
        fetch(32'h0800_0002, 0);
        ack(1'b0, 1'b1, 0, 32'h8);
        fetch(32'h1000_FFFF, 0);
        ack(1'b1, 1'b0, 0, 32'h8);
        fetch(32'h0000_0000, 0);
        ack(1'b0, 1'b0, 0, 32'hC);

        // Reset lands on the second cycle of a stalled request, with a same-cycle response.
        check("mid_req", {31'b0, bus0.IMemReq}, 32'd1);
        check("mid_addr", bus0.IMemAddr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
        @(negedge Clk);
        check("mid_req2", {31'b0, bus0.IMemReq}, 32'd1);
        Rst            = 1'b1;
        bus0.IMemReady = 1'b1;
        bus0.IMemRdata = 32'hCAFE_F00D;
        @(negedge Clk);
        check("mid_rst_req", {31'b0, bus0.IMemReq}, 32'd0);
        check("mid_rst_valid", {31'b0, bus0.InstrValid}, 32'd0);
        check("mid_rst_instr", bus0.Instruction, 32'h0);
        check("mid_rst_addr", bus0.IMemAddr, 32'h0);
        Rst = 1'b0;
        drive_idle();
        exp_q.delete();
        exp_q.push_back(32'h0);

        fetch(32'h0022_1820, 4);
        ack(1'b0, 1'b0, 0, 32'h4);
        fetch(32'h1000_FFFD, 0);
        ack(1'b1, 1'b0, 0, 32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0);
        ack(1'b0, 1'b0, 0, 32'h0);
        fetch(32'h0022_1820, 0);

        check("dut1_still_req", {31'b0, bus1.IMemReq}, 32'd1);
        check("dut1_still_addr", bus1.IMemAddr, 32'h400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
